// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared state type and widths for the mul_share_arb slice
package mul_share_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int OP_W = 4;
    localparam int PRO_W = 8;
    localparam int STAT_W = 8;
endpackage

// File: rtl/mul.sv
// mul: unsigned 4x4 array multiplier, one rca row per partial product
module mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] pro
);
    logic [3:0][7:0] acc;
    assign acc[0] = {4'b0, a & {4{b[0]}}};
    for (genvar i = 1; i < 4; i++) begin : g_row
        rca #(.W(8)) u_rca (
            .a(acc[i-1]),
            .b(8'(a & {4{b[i]}}) << i),
            .s(acc[i])
        );
    end
    assign pro = acc[3];
endmodule

// File: rtl/mul_rr_pick.sv
// mul_rr_pick: combinational round-robin pick, first set req bit at or after ptr
module mul_rr_pick #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any_valid
);
    always_comb begin
        idx = '0;
        // scan farthest-first so the nearest requester after ptr wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) idx = IDW'((int'(ptr) + k) % NREQ);
        end
        any_valid = |req;
        gnt = any_valid ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/rca.sv
// rca: ripple-carry adder; carry-out is dropped, so callers size W to hold the full sum
module rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);
    logic [W-1:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < W - 1; i++) begin : g_c
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign s = a ^ b ^ c;
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one 4x4 multiplier among NREQ requesters.
// Define MUL_SHARE_ARB_STATS_EN to add saturating per-requester grant counters (stat_grants).
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*OP_W-1:0]   req_a,
    input  logic [NREQ*OP_W-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [PRO_W-1:0]       rsp_pro,
    input  logic                   rsp_ready
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);
    state_t          state;
    logic [IDW-1:0]  rr_ptr, op_id, g_idx;
    logic [OP_W-1:0] op_a, op_b;
    logic [NREQ-1:0] g_onehot;
    logic            g_any;
    logic [PRO_W-1:0] pro;

    mul_rr_pick #(.NREQ(NREQ)) u_pick (
        .req(req_valid),
        .ptr(rr_ptr),
        .gnt(g_onehot),
        .idx(g_idx),
        .any_valid(g_any)
    );

    mul u_mul (
        .a(op_a),
        .b(op_b),
        .pro(pro)
    );

    assign req_ready = (state == IDLE) ? g_onehot : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_pro   <= '0;
        end else begin
            case (state)
                IDLE: if (g_any) begin
                    op_a   <= req_a[OP_W*g_idx +: OP_W];
                    op_b   <= req_b[OP_W*g_idx +: OP_W];
                    op_id  <= g_idx;
                    rr_ptr <= (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
                    state  <= EXEC;
                end
                EXEC: begin
                    rsp_pro   <= pro;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_SHARE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stat_grants <= '0;
        else if (state == IDLE && g_any && stat_grants[STAT_W*g_idx +: STAT_W] != '1)
            stat_grants[STAT_W*g_idx +: STAT_W] <= stat_grants[STAT_W*g_idx +: STAT_W] + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed and randomized checks of mul_share_arb against a queue-free
// arbitration model; define MUL_SHARE_ARB_STATS_EN to also exercise the grant counters.
module tb_mul_share_arb;
    logic        clk = 0, rst_n = 0, rsp_ready = 0;
    logic [3:0]  req_valid = 0, req_ready;
    logic [15:0] req_a = 0, req_b = 0;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_pro;
`ifdef MUL_SHARE_ARB_STATS_EN
    logic [31:0] stat_grants;
`endif
    int n_tests = 0, n_fail = 0;
    int exp_ptr = 0;
    logic [3:0] o_ready, o_exec_ready, o_post_ready;
    logic       o_exec_valid, o_valid, o_stable, o_after;
    logic [1:0] o_id;
    logic [7:0] o_pro;

    always #5 clk = ~clk;

    mul_share_arb #(.NREQ(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_a(req_a),
        .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_pro(rsp_pro),
        .rsp_ready(rsp_ready)
`ifdef MUL_SHARE_ARB_STATS_EN
        ,
        .stat_grants(stat_grants)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // round-robin rule: first valid requester at or after the pointer, wrapping
    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++)
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        return (g < 0) ? 4'b0 : 4'(1 << g);
    endfunction

    function automatic logic [7:0] prod(input logic [15:0] a, input logic [15:0] b, input int g);
        int x, y;
        x = int'(a[4*g +: 4]);
        y = int'(b[4*g +: 4]);
        return 8'(x * y);
    endfunction

    // one transaction from IDLE; late bits are raised after the accept; only observes
    task automatic run_txn(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] late, input int stall);
        req_valid = v; req_a = a; req_b = b; rsp_ready = 0;
        #1 o_ready = req_ready;
        tick();
        req_valid = (v & ~o_ready) | late;
        #1 o_exec_ready = req_ready; o_exec_valid = rsp_valid;
        tick();
        o_valid = rsp_valid; o_id = rsp_id; o_pro = rsp_pro;
        o_stable = (req_ready === 4'b0);
        repeat (stall) begin
            tick();
            if (rsp_valid !== o_valid || rsp_id !== o_id || rsp_pro !== o_pro || req_ready !== 4'b0)
                o_stable = 0;
        end
        rsp_ready = 1;
        tick();
        o_after = rsp_valid; o_post_ready = req_ready;
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 0; rsp_ready = 0;
        repeat (2) begin
            tick();
            n_tests++;
            if (rsp_valid !== 1'b0 || req_ready !== 4'b0 || rsp_pro !== 8'h00) begin
                n_fail++;
                $display("FAIL reset: valid=%b ready=%b pro=%h, want 0/0000/00", rsp_valid, req_ready, rsp_pro);
            end
        end
        rst_n = 1; exp_ptr = 0;
        repeat (3) begin
            tick();
            n_tests++;
            if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
                n_fail++;
                $display("FAIL idle: valid=%b ready=%b, want 0/0000", rsp_valid, req_ready);
            end
        end
    endtask

    task automatic test_round_robin();
        for (int n = 0; n < 5; n++) begin
            int g;
            g = pick(4'b1111, exp_ptr);
            run_txn(4'b1111, 16'h4321, 16'h3333, 4'b0, 0);
            exp_ptr = (g + 1) % 4;
            n_tests++;
            if (o_ready !== onehot(g) || o_id !== 2'(g) || o_pro !== prod(16'h4321, 16'h3333, g)) begin
                n_fail++;
                $display("FAIL rr[%0d]: ready=%b id=%0d pro=%0d, want %b/%0d/%0d", n,
                         o_ready, o_id, o_pro, onehot(g), g, prod(16'h4321, 16'h3333, g));
            end
        end
    endtask

    task automatic test_single();
        run_txn(4'b0010, 16'h00F0, 16'h00F0, 4'b0, 0);
        exp_ptr = 2;
        n_tests++;
        if (o_ready !== 4'b0010 || o_exec_valid !== 1'b0 || o_exec_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL single_accept: ready=%b exec_valid=%b exec_ready=%b, want 0010/0/0000",
                     o_ready, o_exec_valid, o_exec_ready);
        end
        n_tests++;
        if (o_valid !== 1'b1 || o_id !== 2'd1 || o_pro !== 8'hE1 || o_after !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: valid=%b id=%0d pro=%h after=%b, want 1/1/e1/0",
                     o_valid, o_id, o_pro, o_after);
        end
    endtask

    task automatic test_backpressure();
        run_txn(4'b0001, 16'h0007, 16'h0009, 4'b0100, 5);
        exp_ptr = 1;
        n_tests++;
        if (o_id !== 2'd0 || o_pro !== 8'd63 || o_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: id=%0d pro=%0d stable=%b, want 0/63/1", o_id, o_pro, o_stable);
        end
        n_tests++;
        if (o_post_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_grant_after: ready=%b, want 0100", o_post_ready);
        end
        run_txn(4'b0100, 16'h0500, 16'h0600, 4'b0, 0);
        exp_ptr = 3;
        n_tests++;
        if (o_id !== 2'd2 || o_pro !== 8'd30) begin
            n_fail++;
            $display("FAIL bp_second: id=%0d pro=%0d, want 2/30", o_id, o_pro);
        end
    endtask

    task automatic test_wrap_reset();
        req_valid = 4'b0001; req_a = 16'h0009; req_b = 16'h0009;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_grant: ready=%b, want 0001", req_ready);
        end
        tick();
        req_valid = 0; rst_n = 0;
        tick();
        rst_n = 1; exp_ptr = 0;
        repeat (4) begin
            tick();
            n_tests++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_midop: rsp_valid=%b, want 0", rsp_valid);
            end
        end
        req_valid = 4'b1111;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL ptr_after_reset: ready=%b, want 0001", req_ready);
        end
        run_txn(4'b1111, 16'h1234, 16'h5678, 4'b0, 0);
        exp_ptr = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  v, late, rem;
            logic [15:0] a, b;
            int g, st;
            v = 4'($urandom_range(1, 15)); late = 4'($urandom);
            a = 16'($urandom); b = 16'($urandom); st = $urandom_range(0, 3);
            g = pick(v, exp_ptr);
            run_txn(v, a, b, late, st);
            exp_ptr = (g + 1) % 4;
            rem = (v & ~onehot(g)) | late;
            n_tests++;
            if (o_ready !== onehot(g) || o_exec_valid !== 1'b0 || o_exec_ready !== 4'b0 ||
                o_valid !== 1'b1 || o_id !== 2'(g) || o_pro !== prod(a, b, g) ||
                o_stable !== 1'b1 || o_after !== 1'b0 || o_post_ready !== onehot(pick(rem, exp_ptr))) begin
                n_fail++;
                $display("FAIL rand[%0d]: v=%b ready=%b id=%0d pro=%0d stable=%b after=%b post=%b, want %b/%0d/%0d/1/0/%b",
                         n, v, o_ready, o_id, o_pro, o_stable, o_after, o_post_ready,
                         onehot(g), g, prod(a, b, g), onehot(pick(rem, exp_ptr)));
            end
        end
    endtask

`ifdef MUL_SHARE_ARB_STATS_EN
    task automatic test_stats();
        rst_n = 0; req_valid = 0;
        tick();
        rst_n = 1; exp_ptr = 0;
        n_tests++;
        if (stat_grants !== 32'b0) begin
            n_fail++;
            $display("FAIL stats_reset: got %h, want 0", stat_grants);
        end
        for (int n = 0; n < 300; n++) begin
            run_txn(4'b0001, 16'h0003, 16'h0005, 4'b0, 0);
            if (n == 9) begin
                n_tests++;
                if (stat_grants !== 32'h0000_000A) begin
                    n_fail++;
                    $display("FAIL stats_count: got %h, want 0000000a", stat_grants);
                end
            end
        end
        n_tests++;
        if (stat_grants !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL stats_sat: got %h, want 000000ff", stat_grants);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_wrap_reset();
        test_random();
`ifdef MUL_SHARE_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
